bram: RTL and testbench

BRAM -- requirements
Module: bram

---
 rtl/bram_if.sv | 13 +
 rtl/bram.sv | 58 +++++
 tb/tb_bram.sv | 111 +++++++++++
 3 files changed

// File: rtl/bram_if.sv
// rtl/bram_if.sv - single-port BRAM access bundle: write strobe, shared address, write/read data.
interface bram_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  wr;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (output wr, output addr, output data_in, input data_out);
  modport slave  (input wr, input addr, input data_in, output data_out);
endinterface

// File: rtl/bram.sv
// rtl/bram.sv - single-port read-first block RAM with registered read data.
// Defining BRAM_OUT_REG_EN adds a second output register (read latency 2).
module bram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_DEPTH = 2 ** ADDR_WIDTH
) (
  input  logic   clk,
  input  logic   rst,
  bram_if.slave  bus
);

  // Zero power-up contents; reset deliberately leaves the array untouched.
  logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH] = '{default: '0};
  logic [DATA_WIDTH-1:0] rd_d;
  logic [DATA_WIDTH-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (!rst && bus.wr) begin
      mem_q[bus.addr] <= bus.data_in;
    end
  end

  // Read samples the pre-write word, giving read-first behaviour.
  always_comb begin
    rd_d = mem_q[bus.addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

`ifdef BRAM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] out_d;
  logic [DATA_WIDTH-1:0] out_q;

  always_comb begin
    out_d = rd_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign bus.data_out = out_q;
`else
  assign bus.data_out = rd_q;
`endif

endmodule

// File: tb/tb_bram.sv
// tb/tb_bram.sv - directed self-checking bench for bram (latency follows BRAM_OUT_REG_EN).
module tb_bram;
`ifdef BRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [15:0] wide;

  bram_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  bram #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DATA_DEPTH(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input logic [7:0] obs, input logic [7:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic write(input logic [3:0] a, input logic [7:0] d);
    bus.wr      = 1'b1;
    bus.addr    = a;
    bus.data_in = d;
    step();
    bus.wr      = 1'b0;
  endtask

  task automatic read_check(input logic [3:0] a, input logic [7:0] exp, input string tag);
    bus.wr   = 1'b0;
    bus.addr = a;
    repeat (LAT) step();
    chk(bus.data_out, exp, tag);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    bus.wr      = 1'b0;
    bus.addr    = '0;
    bus.data_in = '0;
    repeat (2) step();
    chk(bus.data_out, 8'h00, "reset_state");

    // Write attempted under reset must be dropped.
    bus.wr      = 1'b1;
    bus.addr    = 4'd5;
    bus.data_in = 8'h77;
    step();
    rst = 1'b0;
    read_check(4'd5, 8'h00, "wr_during_rst");

    // Truncated write, read-first then new value.
    wide        = 16'h1555;
    bus.wr      = 1'b1;
    bus.addr    = 4'd6;
    bus.data_in = wide[7:0];
    step();
    bus.wr = 1'b0;
    repeat (LAT - 1) step();
    chk(bus.data_out, 8'h00, "read_first_old");
    step();
    chk(bus.data_out, 8'h55, "read_first_new");

    rst = 1'b1;
    repeat (2) step();
    chk(bus.data_out, 8'h00, "rst_clears_out");
    rst = 1'b0;
    read_check(4'd6, 8'h55, "mem_kept_over_rst");

    for (int k = 0; k < 16; k++) begin
      write(k[3:0], 8'h10 + 8'(k));
    end
    for (int k = 0; k < 16 + LAT - 1; k++) begin
      if (k < 16) bus.addr = k[3:0];
      step();
      if (k >= LAT - 1) chk(bus.data_out, 8'h10 + 8'(k - LAT + 1), "seq_read");
    end

    write(4'd3, 8'hAA);
    write(4'd3, 8'hBB);
    read_check(4'd3, 8'hBB, "last_write_wins");

    write(4'd15, 8'hF0);
    write(4'd0, 8'h0F);
    read_check(4'd15, 8'hF0, "top_addr");
    read_check(4'd0, 8'h0F, "addr_zero");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
